// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issue stage:
//   - 3-bit opcode constants understood by the external ALU
//   - issue FSM state type
//   - packed command word as stored in the command FIFO
package alu_pkg;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] MUL  = 3'b010;
  localparam logic [2:0] AND  = 3'b011;
  localparam logic [2:0] OR   = 3'b100;
  localparam logic [2:0] NOT  = 3'b101;
  localparam logic [2:0] XOR  = 3'b110;
  localparam logic [2:0] XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       chain;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for alu_issue_ctrl.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   push     : write wdata at the tail (caller guarantees not full)
//   wdata    : command word
//   pop      : advance the head (caller guarantees not empty)
//   rdata    : command at the head (combinational read)
//   count    : occupancy, 0..DEPTH
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command issue and result capture for the 4-bit/3-bit-op/8-bit-result ALU.
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : command handshake; in_ready = FIFO not full
//   in_a, in_b, in_op  : operands and opcode
//   in_chain           : take operand a from low nibble of the previous result
//   alu_a/alu_b/alu_op : registered operands driven to the external ALU
//   alu_rslt           : combinational ALU result
//   out_valid/out_ready: result handshake
//   out_rslt, out_op   : captured result and the opcode that produced it
//   count              : command FIFO occupancy
//   busy               : FSM not idle or commands queued
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_a,
  input  logic [3:0]             in_b,
  input  logic [2:0]             in_op,
  input  logic                   in_chain,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_op,
  input  logic [7:0]             alu_rslt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_rslt,
  output logic [2:0]             out_op,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t     state;
  state_t     state_nxt;
  logic       push;
  logic       pop;
  cmd_t       wcmd;
  cmd_t       head;
  logic [7:0] last_rslt;

  // in_ready comes only from the registered count: no bypass when full.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign wcmd     = {in_chain, in_op, in_a, in_b};
  assign busy     = (state != IDLE) || (count != '0);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (out_ready) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_valid <= 1'b0;
      out_rslt  <= '0;
      out_op    <= '0;
      last_rslt <= '0;
    end else begin
      state <= state_nxt;
      // Pops only follow a capture, so last_rslt already holds the
      // previous command's result when a chained operand is resolved.
      if (pop) begin
        alu_a  <= head.chain ? last_rslt[3:0] : head.a;
        alu_b  <= head.b;
        alu_op <= head.op;
      end
      if (state == EXEC) begin
        out_rslt  <= alu_rslt;
        out_op    <= alu_op;
        last_rslt <= alu_rslt;
        out_valid <= 1'b1;
      end else if (state == WAIT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;
  logic       in_chain;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_rslt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_rslt;
  logic [2:0] out_op;
  logic [2:0] count;
  logic       busy;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Reference model state: expected {op, rslt} in issue order, observed
  // handshakes, and the result a chained command would consume.
  logic [10:0] exp_q[$];
  logic [10:0] act_q[$];
  int          act_cyc[$];
  logic [7:0]  last_m;

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_chain  (in_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_rslt  (alu_rslt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rslt  (out_rslt),
    .out_op    (out_op),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    case (op)
      ADD:     return {4'b0, a} + {4'b0, b};
      SUB:     return {4'b0, a} - {4'b0, b};
      MUL:     return {4'b0, a} * {4'b0, b};
      AND:     return {4'b0, a & b};
      OR:      return {4'b0, a | b};
      NOT:     return {4'b0, ~a};
      XOR:     return {4'b0, a ^ b};
      default: return {4'b0, ~(a ^ b)};
    endcase
  endfunction

  // Behavioural ALU seen by the DUT.
  assign alu_rslt = alu_fn(alu_a, alu_b, alu_op);

  // Transaction monitor: every accepted command yields one expected result in
  // order; every output handshake yields one observed result.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
      act_q.delete();
      act_cyc.delete();
      last_m = 8'h00;
    end else begin
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        logic [7:0] r;
        r = alu_fn(in_chain ? last_m[3:0] : in_a, in_b, in_op);
        last_m = r;
        exp_q.push_back({in_op, r});
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        act_q.push_back({out_op, out_rslt});
        act_cyc.push_back(cyc);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push_cmd(input logic ch, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_chain = ch;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) begin
      nvec++;
      nfail++;
      $display("FAIL push_accept: in_ready stayed 0 for 100 cycles, required 1");
    end
  endtask

  task automatic push_rand();
    push_cmd(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // Bounded wait for the block to go idle; returns at posedge+1.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_chain = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({out_valid, count, busy, in_ready} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL reset_ctrl: out_valid=%b count=%0d busy=%b in_ready=%b, required 0 0 0 1",
               out_valid, count, busy, in_ready);
    end
    nvec++;
    if ({alu_a, alu_b, alu_op, out_rslt, out_op} !== '0) begin
      nfail++;
      $display("FAIL reset_data: alu_a=%h alu_b=%h alu_op=%h out_rslt=%h out_op=%h, required all 0",
               alu_a, alu_b, alu_op, out_rslt, out_op);
    end
    sync();
  endtask

  task automatic test_add_timing();
    bit ok;
    out_ready = 1'b1;
    push_cmd(1'b0, ADD, 4'd4, 4'd5);     // accepted at edge N
    @(negedge clk);                       // between N and N+1
    @(negedge clk);                       // after N+1
    nvec++;
    if ({alu_a, alu_b, alu_op, out_valid} !== {4'd4, 4'd5, ADD, 1'b0}) begin
      nfail++;
      $display("FAIL add_issue: alu_a=%h alu_b=%h alu_op=%h out_valid=%b, required 4 5 0 0",
               alu_a, alu_b, alu_op, out_valid);
    end
    @(negedge clk);                       // after N+2
    nvec++;
    if ({out_valid, out_op, out_rslt} !== {1'b1, ADD, 8'h09}) begin
      nfail++;
      $display("FAIL add_result: out_valid=%b out_op=%h out_rslt=%h, required 1 0 09",
               out_valid, out_op, out_rslt);
    end
    @(posedge clk);
    #1;
    wait_idle(ok);
    nvec++;
    if (!ok || act_q.size() != exp_q.size()) begin
      nfail++;
      $display("FAIL add_count: got %0d results, expected %0d (idle=%0b)", act_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (act_q[i] !== exp_q[i]) begin
        nfail++;
        $display("FAIL add_model[%0d]: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); act_cyc.delete();
  endtask

  task automatic test_sub_mul_chain();
    bit ok;
    out_ready = 1'b1;
    push_cmd(1'b0, SUB, 4'd3, 4'd5);
    push_cmd(1'b0, MUL, 4'd15, 4'd15);
    push_cmd(1'b0, MUL, 4'd15, 4'd15);
    push_cmd(1'b1, ADD, 4'($urandom), 4'd1);
    wait_idle(ok);
    nvec++;
    if (!ok || act_q.size() != 4) begin
      nfail++;
      $display("FAIL smc_count: got %0d results, expected 4 (idle=%0b)", act_q.size(), ok);
    end
    if (act_q.size() == 4) begin
      nvec++;
      if (act_q[0] !== {SUB, 8'hFE} || act_q[1] !== {MUL, 8'hE1}) begin
        nfail++;
        $display("FAIL sub_mul: got %h %h, expected %h %h", act_q[0], act_q[1], {SUB, 8'hFE}, {MUL, 8'hE1});
      end
      nvec++;
      if (act_q[3] !== {ADD, 8'h02}) begin
        nfail++;
        $display("FAIL chain_result: got %h, expected %h", act_q[3], {ADD, 8'h02});
      end
    end
    nvec++;
    if (alu_a !== 4'h1) begin
      nfail++;
      $display("FAIL chain_alu_a: got %h, expected 1", alu_a);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (act_q[i] !== exp_q[i]) begin
        nfail++;
        $display("FAIL smc_model[%0d]: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); act_cyc.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic ch6;
    logic [2:0] op6;
    logic [3:0] a6, b6;
    out_ready = 1'b0;
    repeat (5) push_rand();
    @(negedge clk);
    nvec++;
    if ({count, in_ready, out_valid} !== {3'd4, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL bp_full: count=%0d in_ready=%b out_valid=%b, required 4 0 1", count, in_ready, out_valid);
    end
    ch6 = 1'($urandom_range(0, 1)); op6 = 3'($urandom); a6 = 4'($urandom); b6 = 4'($urandom);
    in_valid = 1'b1; in_chain = ch6; in_op = op6; in_a = a6; in_b = b6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nvec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() != 5 ||
          {out_op, out_rslt} !== exp_q[0]) begin
        nfail++;
        $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b held=%h queued=%0d, required 0 1 %h 5",
                 k, in_ready, out_valid, {out_op, out_rslt}, exp_q.size(), exp_q[0]);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_cmd(ch6, op6, a6, b6);
    wait_idle(ok);
    nvec++;
    if (!ok || act_q.size() != 6 || exp_q.size() != 6) begin
      nfail++;
      $display("FAIL bp_count: got %0d results, expected 6 (model %0d, idle=%0b)", act_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (act_q[i] !== exp_q[i]) begin
        nfail++;
        $display("FAIL bp_order[%0d]: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < act_cyc.size(); i++) begin
      nvec++;
      if (act_cyc[i] - act_cyc[i-1] != 2) begin
        nfail++;
        $display("FAIL bp_spacing[%0d]: got %0d cycles between results, expected 2", i, act_cyc[i] - act_cyc[i-1]);
      end
    end
    act_q.delete(); exp_q.delete(); act_cyc.delete();
  endtask

  task automatic test_push_pop_wrap();
    bit ok;
    out_ready = 1'b0;
    repeat (3) push_rand();
    for (int r = 0; r < 6; r++) begin
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      nvec++;
      if (!ok || count !== 3'd2) begin
        nfail++;
        $display("FAIL wrap_pre[%0d]: out_valid seen=%0b count=%0d, required 1 2", r, ok, count);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_chain = 1'($urandom_range(0, 1)); in_op = 3'($urandom);
      in_a = 4'($urandom); in_b = 4'($urandom);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      nvec++;
      if (count !== 3'd2) begin
        nfail++;
        $display("FAIL wrap_count[%0d]: got %0d after push+pop, expected 2", r, count);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle(ok);
    nvec++;
    if (!ok || act_q.size() != 9 || exp_q.size() != 9) begin
      nfail++;
      $display("FAIL wrap_total: got %0d results, expected 9 (model %0d, idle=%0b)", act_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (act_q[i] !== exp_q[i]) begin
        nfail++;
        $display("FAIL wrap_order[%0d]: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); act_cyc.delete();
  endtask

  task automatic test_reset_in_exec();
    out_ready = 1'b0;
    repeat (4) push_rand();              // first in WAIT, three queued
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_chain = 1'b0; in_op = 3'($urandom); in_a = 4'($urandom); in_b = 4'($urandom);
    out_ready = 1'b1;                    // release first result, pop + push together
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    nvec++;
    if (act_q.size() != 1 || exp_q.size() != 5 || act_q[0] !== exp_q[0]) begin
      nfail++;
      $display("FAIL rst_first: got %0d results (first %h), expected 1 (first %h)", act_q.size(), act_q[0], exp_q[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({count, out_valid, busy} !== {3'd3, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL rst_pre: count=%0d out_valid=%b busy=%b, required 3 0 1", count, out_valid, busy);
    end
    @(negedge clk);                      // after the reset edge
    nvec++;
    if ({out_valid, count, busy, in_ready} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL rst_ctrl: out_valid=%b count=%0d busy=%b in_ready=%b, required 0 0 0 1",
               out_valid, count, busy, in_ready);
    end
    nvec++;
    if ({alu_a, alu_b, alu_op, out_rslt, out_op} !== '0) begin
      nfail++;
      $display("FAIL rst_data: alu_a=%h alu_b=%h alu_op=%h out_rslt=%h out_op=%h, required all 0",
               alu_a, alu_b, alu_op, out_rslt, out_op);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        nfail++;
        $display("FAIL rst_stale[%0d]: out_valid=%b busy=%b, required 0 0", k, out_valid, busy);
      end
    end
    nvec++;
    if (act_q.size() != 0) begin
      nfail++;
      $display("FAIL rst_emitted: got %0d results after reset, expected 0", act_q.size());
    end
    sync();
  endtask

  task automatic test_random_traffic();
    bit ok;
    for (int k = 0; k < 300; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_chain  = 1'($urandom_range(0, 1));
      in_op     = 3'($urandom);
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      nvec++;
      if (in_ready !== (count != 3'd4) || count > 3'd4) begin
        nfail++;
        $display("FAIL rnd_ready[%0d]: in_ready=%b count=%0d, required in_ready = (count != 4)", k, in_ready, count);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle(ok);
    nvec++;
    if (!ok || act_q.size() != exp_q.size()) begin
      nfail++;
      $display("FAIL rnd_count: got %0d results, expected %0d (idle=%0b)", act_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (act_q[i] !== exp_q[i]) begin
        nfail++;
        $display("FAIL rnd_model[%0d]: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); act_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_sub_mul_chain();
    test_backpressure();
    test_push_pop_wrap();
    test_reset_in_exec();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command issue and result-capture stage for the 4-bit-operand / 3-bit-opcode / 8-bit-result combinational ALU. Buffers operation commands from a valid/ready source in a small FIFO and drives one command at a time onto the ALU's `a`/`b`/`opcode` inputs. It registers the ALU's `rslt` and presents it downstream with a valid/ready handshake. A chain mode substitutes the low nibble of the previous result for operand `a`, enabling accumulate-style sequences.

## Interface
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: command present.
- `in_ready` out 1: FIFO can accept; equals `count != DEPTH`.
- `in_a`, `in_b` in 4: operands.
- `in_op` in 3: opcode, passed to ALU unchanged.
- `in_chain` in 1: 1 = use `last_rslt[3:0]` as `a`; `in_a` ignored.
- `alu_a`, `alu_b` out 4: registered ALU operands.
- `alu_op` out 3: registered ALU opcode.
- `alu_rslt` in 8: ALU result, combinational from `alu_*`.
- `out_valid` out 1: result held.
- `out_ready` in 1: downstream accepts.
- `out_rslt` out 8: captured result.
- `out_op` out 3: opcode that produced `out_rslt`.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: state != IDLE or `count` != 0.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `{in_chain, in_op, in_a, in_b}` to the tail. There is no bypass: a full FIFO deasserts `in_ready` even in a cycle that pops.
- FSM states: IDLE, EXEC, WAIT.
  - IDLE: if `count != 0`, pop the head, load `alu_a/alu_b/alu_op`, then go to EXEC. Otherwise stay.
  - EXEC, exactly one cycle: `out_rslt <= alu_rslt`, `out_op <= alu_op`, `last_rslt <= alu_rslt`, `out_valid <= 1`, then go to WAIT.
  - WAIT: while `out_ready == 0`, hold everything. When `out_ready == 1`: `out_valid <= 0`. If `count != 0`, pop and go to EXEC (back-to-back); otherwise go to IDLE.
- Chain resolution happens at pop time: `alu_a <= chain ? last_rslt[3:0] : a`. `last_rslt` is always current at pop, because pops occur only after the previous capture.
- `alu_*` hold their last issued values between commands.
- A push and a pop in the same cycle: `count` is unchanged, and both pointers advance.
- Pointers wrap modulo `DEPTH`. `count` ranges from 0 to `DEPTH`.
- Reset clears the following, regardless of state and discarding any in-flight command:
  - `count`, the pointers, `out_valid`, `out_rslt`, `out_op`, `last_rslt`, `alu_a`, `alu_b`, `alu_op` → 0.
  - state → IDLE.
  - `in_ready` → 1 the cycle after reset.

## Timing
- Empty FIFO, idle, command accepted at edge N:
  - edge N+1: `alu_*` valid.
  - edge N+2: `out_valid = 1`.
- Throughput: one result per 2 cycles with `out_ready` held high.
- `out_rslt`/`out_op` are stable while `out_valid && !out_ready`.
- The ALU path from `alu_*` to `alu_rslt` must settle within one clock (EXEC).
- `in_ready` and `out_valid` are registered or derived only from registered state. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `alu_pkg`:
  - opcode constants ADD=000, SUB=001, MUL=010, AND=011, OR=100, NOT=101, XOR=110, XNOR=111;
  - FSM state enum;
  - packed command struct {chain, op[2:0], a[3:0], b[3:0]}.
- Sub-module `alu_cmd_fifo`: synchronous FIFO, parameterized by `DEPTH`, with a count output. The FSM and capture registers live in `alu_issue_ctrl`.
- The ALU is instantiated outside this block; the bench connects a behavioural ALU model.

## Test plan
- ADD 4+5 pushed into an idle block with `out_ready=1` → `out_rslt=0x09`, `out_op=000`, `out_valid` high 2 cycles after accept.
- SUB 3−5 → `out_rslt=0xFE`. MUL 15×15 → `0xE1`.
- Chain: MUL 15×15, then ADD chain with b=1 → second `alu_a=0x1`, `out_rslt=0x02`.
- Backpressure: hold `out_ready=0` and push 6 commands:
  - `in_ready` falls once `count=4` (the first command is in WAIT);
  - the sixth command stalls;
  - release `out_ready` → results emerge in order, one every 2 cycles.
- Simultaneous push and pop in WAIT with `count=2` → `count` stays 2, and the order is preserved across pointer wrap.
- Assert `rst` during EXEC with 3 queued commands → next cycle: `out_valid=0`, `count=0`, `alu_*=0`, state IDLE, no stale result emitted.
